// File: rtl/vme_cmd_player.sv
// vme_cmd_player: replays a host-loaded buffer of VME read/write commands through the cmd/data handshake.
// Define CMD_PLAYER_LOOP_EN to replay the buffer loop_n+1 times per run (adds loop_n, pass_idx).
module vme_cmd_player #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int DEPTH = 16,
  parameter logic [31:0] MASK = 32'h00A80000,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic          load_rd,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          load_full,
  input  logic          clr,
  input  logic          run,
  output logic          busy,
  output logic          done,
  input  logic          vme_cmd_rd,
  input  logic          vme_dat_wr,
  input  logic [31:0]   vme_dat_reg_out,
  output logic          start,
  output logic [31:0]   vme_cmd_reg,
  output logic [31:0]   vme_dat_reg_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_rd,
  output logic          res_tmo,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_data,
`ifdef CMD_PLAYER_LOOP_EN
  input  logic [7:0]    loop_n,
  output logic [7:0]    pass_idx,
`endif
  output logic [7:0]    err_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, WAIT_RDY = 3'd1, ISSUE = 3'd2, WAIT_ACK = 3'd3, RESULT = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] count;
  logic [PW-1:0] ptr;
  logic [TW-1:0] tcnt;
  logic rd_mem [DEPTH];
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic cur_rd, active, load_ok, ack, tmo, pass_end, last, unused_bits;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  assign cur_rd = rd_mem[ptr];
  assign cur_addr = addr_mem[ptr];
  assign cur_data = data_mem[ptr];
  assign active = state == ISSUE || state == WAIT_ACK;
  assign load_full = count == CW'(DEPTH);
  assign load_ok = state == IDLE && load_valid && !load_full && !clr;
  assign ack = state == WAIT_ACK && vme_dat_wr;
  assign tmo = state == WAIT_ACK && !vme_dat_wr && tcnt == TW'(TIMEOUT - 1);
  assign pass_end = {1'b0, ptr} == count - 1'b1;
  assign busy = state != IDLE;
  assign start = state == ISSUE;
  assign res_valid = state == RESULT;
  assign vme_cmd_reg = active ? MASK | {6'b0, cur_rd, ~cur_rd, 8'b0, 16'(cur_addr)} : MASK;
  assign vme_dat_reg_in = active && !cur_rd ? 32'(cur_data) : 32'b0;
  assign unused_bits = ^vme_dat_reg_out;
`ifdef CMD_PLAYER_LOOP_EN
  logic [7:0] loop_r;
  assign last = pass_end && pass_idx == loop_r;
`else
  assign last = pass_end;
`endif
  // Buffer storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk)
    if (load_ok) begin
      rd_mem[count[PW-1:0]] <= load_rd;
      addr_mem[count[PW-1:0]] <= load_addr;
      data_mem[count[PW-1:0]] <= load_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      ptr <= '0;
      tcnt <= '0;
      done <= 1'b0;
      res_rd <= 1'b0;
      res_tmo <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
      err_cnt <= '0;
`ifdef CMD_PLAYER_LOOP_EN
      loop_r <= '0;
      pass_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) count <= '0;
          else if (load_ok) count <= count + 1'b1;
          if (run) begin
            ptr <= '0;
            done <= count == '0;
            state <= count == '0 ? IDLE : WAIT_RDY;
`ifdef CMD_PLAYER_LOOP_EN
            loop_r <= loop_n;
            pass_idx <= '0;
`endif
          end
        end
        WAIT_RDY: if (vme_cmd_rd) state <= ISSUE;
        ISSUE: begin
          tcnt <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          tcnt <= tcnt + 1'b1;
          if (ack || tmo) begin
            res_rd <= cur_rd;
            res_addr <= cur_addr;
            res_tmo <= tmo;
            res_data <= tmo ? '0 : cur_rd ? vme_dat_reg_out[DW-1:0] : cur_data;
            err_cnt <= err_cnt + {7'b0, tmo && err_cnt != 8'hFF};
            state <= RESULT;
          end
        end
        RESULT:
          if (res_ready) begin
            ptr <= pass_end ? '0 : ptr + 1'b1;
            done <= last;
            state <= last ? IDLE : WAIT_RDY;
`ifdef CMD_PLAYER_LOOP_EN
            if (pass_end && !last) pass_idx <= pass_idx + 1'b1;
`endif
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vme_cmd_player.sv
// tb_vme_cmd_player: table-driven replay checks plus hand-written reset, empty-run and clr sequences.
module tb_vme_cmd_player;
  localparam logic [31:0] MASK = 32'h00A80000;
  logic clk = 0, rst = 1;
  logic load_valid = 0, load_rd = 0, clr = 0, run = 0;
  logic [15:0] load_addr = 0, load_data = 0;
  logic vme_cmd_rd = 1, vme_dat_wr = 0, res_ready = 0;
  logic [31:0] vme_dat_reg_out = 0;
  logic load_full, busy, done, start, res_valid, res_rd, res_tmo;
  logic [31:0] vme_cmd_reg, vme_dat_reg_in;
  logic [15:0] res_addr, res_data;
  logic [7:0] err_cnt;
`ifdef CMD_PLAYER_LOOP_EN
  logic [7:0] loop_n = 0;
  logic [7:0] pass_idx;
`endif
  int n_chk = 0, n_fail = 0, starts = 0, dones = 0;

  vme_cmd_player #(.DW(16), .AW(16), .DEPTH(4), .MASK(MASK), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_rd(load_rd), .load_addr(load_addr),
    .load_data(load_data), .load_full(load_full), .clr(clr), .run(run), .busy(busy), .done(done),
    .vme_cmd_rd(vme_cmd_rd), .vme_dat_wr(vme_dat_wr), .vme_dat_reg_out(vme_dat_reg_out),
    .start(start), .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd), .res_tmo(res_tmo),
    .res_addr(res_addr), .res_data(res_data),
`ifdef CMD_PLAYER_LOOP_EN
    .loop_n(loop_n), .pass_idx(pass_idx),
`endif
    .err_cnt(err_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (start === 1'b1) starts++;
    if (done === 1'b1) dones++;
  end

  typedef struct {
    logic rd;
    logic [15:0] addr;
    logic [15:0] data;
    int dly;
    logic [15:0] rdata;
    logic [31:0] cmd;
    logic [31:0] din;
    logic tmo;
    logic [15:0] rres;
  } vec_t;
  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    load_valid = 1;
    load_rd = v.rd;
    load_addr = v.addr;
    load_data = v.data;
    tick();
    load_valid = 0;
  endtask

  task automatic wait_start();
    int k = 0;
    while (start !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("start_seen", {31'b0, start}, 1);
  endtask

  // Play one command from ISSUE to result acceptance; dly < 0 means never acknowledge.
  task automatic play(input vec_t v, input int hold);
    wait_start();
    chk("cmd_reg", vme_cmd_reg, v.cmd);
    chk("dat_in", vme_dat_reg_in, v.din);
    if (v.dly < 0) begin
      repeat (8) begin
        tick();
        chk("tmo_pending", {31'b0, res_valid}, 0);
      end
      tick();
    end else begin
      repeat (v.dly) tick();
      chk("cmd_held", vme_cmd_reg, v.cmd);
      vme_dat_wr = 1;
      vme_dat_reg_out = {16'hBEEF, v.rdata};
      tick();
      vme_dat_wr = 0;
    end
    chk("res_valid", {31'b0, res_valid}, 1);
    chk("res_rd", {31'b0, res_rd}, {31'b0, v.rd});
    chk("res_addr", {16'b0, res_addr}, {16'b0, v.addr});
    chk("res_data", {16'b0, res_data}, {16'b0, v.rres});
    chk("res_tmo", {31'b0, res_tmo}, {31'b0, v.tmo});
    repeat (hold) begin
      tick();
      chk("hold_valid", {31'b0, res_valid}, 1);
      chk("hold_data", {16'b0, res_data}, {16'b0, v.rres});
      chk("hold_start", {31'b0, start}, 0);
    end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  initial begin
    int s0, d0;
    tbl[0] = '{1'b0, 16'h4100, 16'h00AB, 3, 16'hDEAD, 32'h01A84100, 32'h000000AB, 1'b0, 16'h00AB};
    tbl[1] = '{1'b1, 16'h4200, 16'h7777, 3, 16'h1234, 32'h02A84200, 32'h00000000, 1'b0, 16'h1234};
    tbl[2] = '{1'b0, 16'h00FF, 16'h5A5A, -1, 16'h0000, 32'h01A800FF, 32'h00005A5A, 1'b1, 16'h0000};
    tbl[3] = '{1'b1, 16'h4300, 16'h0000, 1, 16'hC0DE, 32'h02A84300, 32'h00000000, 1'b0, 16'hC0DE};
    tbl[4] = '{1'b1, 16'h1111, 16'h0000, 1, 16'h0000, 32'h02A81111, 32'h00000000, 1'b0, 16'h0000};
    tick();
    tick();
    chk("rst_cmd_reg", vme_cmd_reg, MASK);
    chk("rst_start", {31'b0, start}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_load_full", {31'b0, load_full}, 0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 0);
    chk("rst_dat_in", vme_dat_reg_in, 0);
`ifdef CMD_PLAYER_LOOP_EN
    chk("rst_pass_idx", {24'b0, pass_idx}, 0);
`endif
    rst = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      load(tbl[i]);
      chk("load_full", {31'b0, load_full}, {31'b0, i >= 3});
    end
    s0 = starts;
    d0 = dones;
    run = 1;
    tick();
    run = 0;
    chk("run_busy", {31'b0, busy}, 1);
    for (int i = 0; i < 4; i++) begin
      play(tbl[i], i == 0 ? 5 : 0);
      chk("done_pulse", {31'b0, done}, {31'b0, i == 3});
    end
    tick();
    chk("done_clear", {31'b0, done}, 0);
    chk("idle_busy", {31'b0, busy}, 0);
    chk("start_count", starts - s0, 4);
    chk("done_count", dones - d0, 1);
    chk("err_cnt", {24'b0, err_cnt}, 1);
    // Abort mid-command with an asynchronous reset.
    run = 1;
    tick();
    run = 0;
    wait_start();
    tick();
    #2 rst = 1;
    #1;
    chk("abort_start", {31'b0, start}, 0);
    chk("abort_cmd_reg", vme_cmd_reg, MASK);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_res_valid", {31'b0, res_valid}, 0);
    chk("abort_load_full", {31'b0, load_full}, 0);
    chk("abort_err_cnt", {24'b0, err_cnt}, 0);
    tick();
    rst = 0;
    s0 = starts;
    run = 1;
    tick();
    run = 0;
    chk("empty_done", {31'b0, done}, 1);
    chk("empty_busy", {31'b0, busy}, 0);
    tick();
    chk("empty_done_clear", {31'b0, done}, 0);
    chk("empty_starts", starts - s0, 0);
    // clr wins over a simultaneous load.
    clr = 1;
    load(tbl[0]);
    clr = 0;
    run = 1;
    tick();
    run = 0;
    chk("clr_wins_done", {31'b0, done}, 1);
`ifdef CMD_PLAYER_LOOP_EN
    load(tbl[0]);
    load(tbl[1]);
    s0 = starts;
    d0 = dones;
    loop_n = 2;
    run = 1;
    tick();
    run = 0;
    for (int p = 0; p < 6; p++) begin
      wait_start();
      chk("pass_idx", {24'b0, pass_idx}, p / 2);
      play(tbl[p % 2], 0);
    end
    tick();
    chk("loop_starts", starts - s0, 6);
    chk("loop_done_count", dones - d0, 1);
    chk("loop_idle", {31'b0, busy}, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
